// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: program counter plus IF/ID pipeline register.
// It drives the instruction-memory address and captures the returned word
// for decode. It also handles stall, flush and branch/jump redirect, and it
// keeps saturating counts of fetched instructions and of inserted bubbles.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        RedirectValid,
  input  logic [31:0] RedirectTarget,
  output logic [31:0] Address,
  input  logic [31:0] Instruction,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic        MisalignedError,
  output logic [31:0] FetchCount,
  output logic [31:0] BubbleCount
);

  // Per-cycle action, listed in priority order: redirect > flush > stall > fetch.
  typedef enum logic [1:0] {
    ACT_FETCH,
    ACT_STALL,
    ACT_FLUSH,
    ACT_REDIRECT
  } action_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;

  action_e     action;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  // Address comes straight from the PC register, so no input reaches it combinationally.
  assign Address  = pc;
  // The carry out of bit 31 is dropped, so the PC wraps 0xFFFF_FFFC -> 0.
  assign pc_plus4 = pc + 32'd4;

  // Pick the single action for this edge from the control inputs.
  always_comb begin
    // NOTE: assign a default before any branch so that no path leaves the
    // signal unassigned; an unassigned path would infer a latch.
    action = ACT_FETCH;
    if (RedirectValid)  action = ACT_REDIRECT;
    else if (Flush)     action = ACT_FLUSH;
    else if (Stall)     action = ACT_STALL;
  end

  // PC and IF/ID register update.
  always_ff @(posedge Clk or negedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the pre-edge values no matter what order the statements are in.
    if (!Reset) begin
      pc               <= RESET_PC;
      IFID_Instruction <= NOP_WORD;
      IFID_PCPlus4     <= 32'd0;
      IFID_Valid       <= 1'b0;
    end else begin
      case (action)
        ACT_REDIRECT: begin
          pc               <= {RedirectTarget[31:2], 2'b00};
          IFID_Instruction <= NOP_WORD;
          IFID_PCPlus4     <= 32'd0;
          IFID_Valid       <= 1'b0;
        end
        ACT_FLUSH: begin
          // The PC holds, so the squashed instruction is fetched again.
          IFID_Instruction <= NOP_WORD;
          IFID_PCPlus4     <= 32'd0;
          IFID_Valid       <= 1'b0;
        end
        ACT_STALL: ;
        default: begin
          pc               <= pc_plus4;
          IFID_Instruction <= Instruction;
          IFID_PCPlus4     <= pc_plus4;
          IFID_Valid       <= 1'b1;
        end
      endcase
    end
  end

  // Sticky flag: set when a redirect target is not word-aligned. Only reset clears it.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      MisalignedError <= 1'b0;
    else if (action == ACT_REDIRECT && RedirectTarget[1:0] != 2'b00)
      MisalignedError <= 1'b1;
  end

  // Saturating statistics: valid fetches and bubbles written into IF/ID.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      FetchCount  <= 32'd0;
      BubbleCount <= 32'd0;
    end else begin
      case (action)
        ACT_FETCH:
          if (FetchCount != CNT_MAX) FetchCount <= FetchCount + 32'd1;
        ACT_REDIRECT, ACT_FLUSH:
          if (BubbleCount != CNT_MAX) BubbleCount <= BubbleCount + 32'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage: directed scenarios followed
// by random control traffic, compared against a behavioural model of the stage.
module tb_instruction_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] address;
  logic [31:0] instruction;
  logic [31:0] ifid_instruction;
  logic [31:0] ifid_pcplus4;
  logic        ifid_valid;
  logic        misaligned_error;
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;

  int total = 0;
  int bad   = 0;

  // Behavioural model state.
  logic [31:0] m_pc, m_instr, m_pc4, m_fetch, m_bubble;
  logic        m_valid, m_mis;

  instruction_fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .Clk              (clk),
    .Reset            (rst_n),
    .Stall            (stall),
    .Flush            (flush),
    .RedirectValid    (redirect_valid),
    .RedirectTarget   (redirect_target),
    .Address          (address),
    .Instruction      (instruction),
    .IFID_Instruction (ifid_instruction),
    .IFID_PCPlus4     (ifid_pcplus4),
    .IFID_Valid       (ifid_valid),
    .MisalignedError  (misaligned_error),
    .FetchCount       (fetch_count),
    .BubbleCount      (bubble_count)
  );

  // Instruction memory: three fixed words at 0, 4 and 8, and a hash of the address elsewhere.
  function automatic logic [31:0] mem_read(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h2008_0001;
      32'h4:   return 32'h2009_0002;
      32'h8:   return 32'h200A_0003;
      default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endcase
  endfunction

  assign instruction = mem_read(address);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".addr"},   address,                m_pc);
    check({tag, ".instr"},  ifid_instruction,       m_instr);
    check({tag, ".pc4"},    ifid_pcplus4,           m_pc4);
    check({tag, ".valid"},  32'(ifid_valid),        32'(m_valid));
    check({tag, ".mis"},    32'(misaligned_error),  32'(m_mis));
    check({tag, ".fetch"},  fetch_count,            m_fetch);
    check({tag, ".bubble"}, bubble_count,           m_bubble);
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_instr = 0; m_pc4 = 0; m_valid = 0;
    m_mis = 0; m_fetch = 0; m_bubble = 0;
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Apply one cycle of controls, advance the model by the stage's rules, then compare.
  task automatic step(input logic s, input logic f, input logic rv,
                      input logic [31:0] tgt, input string tag);
    stall = s; flush = f; redirect_valid = rv; redirect_target = tgt;
    if (rv) begin
      m_pc = tgt & ~32'd3;
      m_instr = 0; m_pc4 = 0; m_valid = 0;
      m_bubble = sat_inc(m_bubble);
      if (tgt % 4 != 0) m_mis = 1;
    end else if (f) begin
      m_instr = 0; m_pc4 = 0; m_valid = 0;
      m_bubble = sat_inc(m_bubble);
    end else if (!s) begin
      m_instr = mem_read(m_pc);
      m_pc4   = m_pc + 32'd4;
      m_valid = 1;
      m_pc    = m_pc4;
      m_fetch = sat_inc(m_fetch);
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; stall = 0; flush = 0; redirect_valid = 0; redirect_target = 0;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;

    // Run from reset, then stall three cycles at Address=8.
    step(0, 0, 0, 0, "run0");
    check("run0.plan_pc4", ifid_pcplus4, 32'd4);
    step(0, 0, 0, 0, "run1");
    check("run1.plan_instr", ifid_instruction, 32'h2009_0002);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, "stall");
      check("stall.plan_addr", address, 32'd8);
      check("stall.plan_pc4", ifid_pcplus4, 32'd8);
    end
    step(0, 0, 0, 0, "release");
    check("release.plan_instr", ifid_instruction, 32'h200A_0003);
    check("release.plan_fetch", fetch_count, 32'd3);

    // Redirect with a simultaneous stall: redirect wins.
    step(1, 0, 1, 32'h40, "redir_stall");
    check("redir_stall.plan_addr", address, 32'h40);
    check("redir_stall.plan_bubble", bubble_count, 32'd1);

    // Flush alone at 0x10 refetches the same word.
    step(0, 0, 1, 32'h10, "to10");
    step(0, 1, 0, 0, "flush");
    check("flush.plan_addr", address, 32'h10);
    step(0, 0, 0, 0, "refetch");
    check("refetch.plan_pc4", ifid_pcplus4, 32'h14);

    // Misaligned target: aligned PC, sticky error.
    step(0, 0, 1, 32'h42, "mis");
    check("mis.plan_addr", address, 32'h40);
    check("mis.plan_flag", 32'(misaligned_error), 32'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, "mis_sticky");

    // PC wrap at the top of the address space.
    step(0, 0, 1, 32'hFFFF_FFFC, "to_top");
    step(0, 0, 0, 0, "wrap");
    check("wrap.plan_addr", address, 32'h0);
    check("wrap.plan_pc4", ifid_pcplus4, 32'h0);

    // Random control traffic.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] r, tgt;
      r   = $urandom_range(0, 99);
      tgt = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 255));
      step(r < 20, (r >= 20 && r < 30), (r >= 30 && r < 38), tgt, "rand");
    end

    // Asynchronous reset asserted between edges in the middle of a stall.
    stall = 1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    check("async_reset.plan_addr", address, RESET_PC);
    check("async_reset.plan_mis", 32'(misaligned_error), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, "post_reset");
    check("post_reset.plan_instr", ifid_instruction, 32'h2008_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Program-counter and IF/ID pipeline-register stage of the pipelined MIPS datapath. It sits directly upstream of the instruction memory: it drives the memory `Address` and captures the returned `Instruction` into the IF/ID register for the decode stage. It handles stall, flush and branch/jump redirect, and it keeps fetch/bubble statistics.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Stall  in  1  hazard-unit hold; PC and IF/ID keep their values.
- Flush  in  1  squash the instruction currently being fetched.
- RedirectValid  in  1  taken branch/jump; load a new PC.
- RedirectTarget  in  32  branch/jump target byte address.
- Address  out  32  byte address to instruction memory; equals the PC register.
- Instruction  in  32  instruction-memory read data; combinational from Address, same cycle.
- IFID_Instruction  out  32  registered instruction to decode.
- IFID_PCPlus4  out  32  registered PC+4 of that instruction.
- IFID_Valid  out  1  1 = real instruction, 0 = bubble.
- MisalignedError  out  1  sticky flag; a redirect target had bits [1:0] != 0.
- FetchCount  out  32  number of valid instructions written into IF/ID; saturating.
- BubbleCount  out  32  number of bubbles written into IF/ID; saturating.

## Operation
- While Reset=0: PC=RESET_PC, IFID_Instruction=0, IFID_PCPlus4=0, IFID_Valid=0, MisalignedError=0, FetchCount=0, BubbleCount=0.
- Each rising edge, the first matching rule applies:
  1. RedirectValid=1: PC <= {RedirectTarget[31:2],2'b00}. IF/ID <= bubble. BubbleCount+1. Stall and Flush are ignored. If RedirectTarget[1:0]!=0, MisalignedError <= 1.
  2. Flush=1: PC holds, so the current instruction is refetched. IF/ID <= bubble. BubbleCount+1. Flush overrides Stall.
  3. Stall=1: PC and IF/ID hold. No counter changes.
  4. Otherwise: PC <= PC+4, wrapping modulo 2^32. IF/ID <= {Instruction, PC+4, Valid=1}. FetchCount+1.
- A bubble is IFID_Instruction=32'h0000_0000 (sll $0,$0,0 nop), IFID_PCPlus4=0, IFID_Valid=0.
- MisalignedError clears only on reset.
- Counters saturate at 32'hFFFF_FFFF and never wrap.
- PC+4 arithmetic is 32-bit unsigned; the carry out is discarded (0xFFFF_FFFC+4 = 0x0000_0000).

## Timing
- Address is a direct wire from the PC register; there is no combinational path from any input to Address.
- Instruction is sampled in the same cycle Address is presented. IF/ID outputs update one edge later (latency 1).
- A redirect takes effect on the edge after it is asserted. The instruction fetched in that cycle is squashed, and the target address appears on Address in the next cycle.
- Reset assertion clears all state immediately, without waiting for a clock edge, including mid-stall or mid-redirect.
- After deassertion, the first edge performs a normal fetch from RESET_PC.
- Stall held for N cycles: Address and IF/ID remain constant for N cycles. The fetch resumes on the first edge with Stall=0.

## Test plan
- Reset then run, with memory words 0x20080001, 0x20090002, 0x200A0003 at 0, 4, 8:
  - Address steps 0 -> 4 -> 8 -> 12.
  - IF/ID shows (0x20080001, 4, 1), then (0x20090002, 8, 1), then (0x200A0003, 12, 1).
  - FetchCount=3.
- Stall 3 cycles at Address=8:
  - Address stays 8 and IF/ID stays (0x20090002, 8, 1) for 3 cycles.
  - On release, IF/ID becomes (0x200A0003, 12, 1).
- RedirectValid=1, RedirectTarget=0x40, Stall=1 simultaneously at Address=8:
  - Next cycle Address=0x40, IFID_Valid=0, IFID_Instruction=0.
  - BubbleCount increments by 1.
- Flush alone at Address=0x10:
  - Next cycle Address=0x10 (held), IFID_Valid=0.
  - The following cycle, IF/ID carries the word at 0x10 with PCPlus4=0x14.
- Redirect to 0x42:
  - Address=0x40 and MisalignedError=1.
  - MisalignedError stays 1 after further normal fetches, and clears only on Reset=0.
- Wrap and async reset:
  - Redirect to 0xFFFF_FFFC, then one fetch: Address=0, IFID_PCPlus4=0.
  - Drive Reset=0 between clock edges: all outputs clear immediately, Address=RESET_PC.
